// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl
// Brief    : Time-multiplexed scan controller for an 8-digit seven-segment
//            display. Shows a 32-bit hex value (one nibble per digit). Each
//            digit slot starts with a blanking gap. New values are held in a
//            shadow buffer and applied only at frame boundaries.
// Ports    : clk         - system clock, rising edge
//            reset       - synchronous active-high reset
//            data_in     - nibble i drives digit i (digit 0 = bits 3:0)
//            mask_in     - per-digit enable, 1 = shown
//            load        - one-cycle strobe capturing data_in/mask_in
//            pending     - a captured value is waiting for the frame boundary
//            frame_start - one-cycle pulse as the digit 0 slot begins
//            num_csn     - digit select, active-low, at most one low
//            num_a_g     - segments, active-high, bit6 = a ... bit0 = g
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
    parameter int SCAN_DIV = 50000,
    parameter int BLANK    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_in,
    input  logic [7:0]  mask_in,
    input  logic        load,
    output logic        pending,
    output logic        frame_start,
    output logic [7:0]  num_csn,
    output logic [6:0]  num_a_g
);

    localparam int c_CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_CW-1:0] c_CNT_LAST  = c_CW'(SCAN_DIV - 1);
    localparam logic [c_CW-1:0] c_BLANK_END = c_CW'(BLANK);

    logic [c_CW-1:0] r_cnt;
    logic [2:0]      r_idx;
    logic [31:0]     r_disp;
    logic [7:0]      r_dmask;
    logic [31:0]     r_sdata;
    logic [7:0]      r_smask;
    logic            r_pending;
    logic            r_frame_start;
    logic [7:0]      r_csn;
    logic [6:0]      r_seg;

    logic            w_slot_end;
    logic            w_boundary;
    logic            w_drive;
    logic [3:0]      w_nib;
    logic [6:0]      w_seg;

    assign w_slot_end = (r_cnt == c_CNT_LAST);
    assign w_boundary = w_slot_end && (r_idx == 3'd7);
    // Lit only past the blanking gap and only for enabled digits.
    assign w_drive    = (r_cnt >= c_BLANK_END) && r_dmask[r_idx];
    assign w_nib      = r_disp[{r_idx, 2'b00} +: 4];

    always_comb begin
        w_seg = 7'h00;
        case (w_nib)
            4'h0: w_seg = 7'h7E;
            4'h1: w_seg = 7'h30;
            4'h2: w_seg = 7'h6D;
            4'h3: w_seg = 7'h79;
            4'h4: w_seg = 7'h33;
            4'h5: w_seg = 7'h5B;
            4'h6: w_seg = 7'h5F;
            4'h7: w_seg = 7'h70;
            4'h8: w_seg = 7'h7F;
            4'h9: w_seg = 7'h7B;
            4'hA: w_seg = 7'h77;
            4'hB: w_seg = 7'h1F;
            4'hC: w_seg = 7'h4E;
            4'hD: w_seg = 7'h3D;
            4'hE: w_seg = 7'h4F;
            4'hF: w_seg = 7'h47;
            default: w_seg = 7'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt         <= '0;
            r_idx         <= 3'd0;
            r_disp        <= 32'h0;
            r_dmask       <= 8'h00;
            r_sdata       <= 32'h0;
            r_smask       <= 8'h00;
            r_pending     <= 1'b0;
            r_frame_start <= 1'b0;
            r_csn         <= 8'hFF;
            r_seg         <= 7'h00;
        end else begin
            // Scan counters
            if (w_slot_end) begin
                r_cnt <= '0;
                r_idx <= r_idx + 3'd1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            // Double buffering: a load coinciding with the boundary bypasses
            // the shadow so the fresher value is shown immediately.
            if (w_boundary) begin
                if (load) begin
                    r_disp  <= data_in;
                    r_dmask <= mask_in;
                end else if (r_pending) begin
                    r_disp  <= r_sdata;
                    r_dmask <= r_smask;
                end
                r_pending <= 1'b0;
            end else if (load) begin
                r_sdata   <= data_in;
                r_smask   <= mask_in;
                r_pending <= 1'b1;
            end

            r_frame_start <= w_boundary;

            // Pins are computed from the pre-edge counters: one cycle of lag.
            if (w_drive) begin
                r_csn <= ~(8'h01 << r_idx);
                r_seg <= w_seg;
            end else begin
                r_csn <= 8'hFF;
                r_seg <= 7'h00;
            end
        end
    end

    assign pending     = r_pending;
    assign frame_start = r_frame_start;
    assign num_csn     = r_csn;
    assign num_a_g     = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_ctrl
// Brief    : Self-checking bench for seg_scan_ctrl (SCAN_DIV = 8, BLANK = 2).
//            A frame-position reference model predicts every output each
//            cycle; directed scenarios plus random loads drive the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

    localparam int c_DIV   = 8;
    localparam int c_BLANK = 2;
    localparam int c_FRAME = 8 * c_DIV;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data_in;
    logic [7:0]  mask_in;
    logic        load;
    logic        pending;
    logic        frame_start;
    logic [7:0]  num_csn;
    logic [6:0]  num_a_g;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state: position within the frame plus buffers.
    int          m_pos;
    logic [31:0] m_disp, m_sdata;
    logic [7:0]  m_mask, m_smask;
    logic        m_pend;

    logic [6:0] segtab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B,
                                7'h5F, 7'h70, 7'h7F, 7'h7B, 7'h77, 7'h1F,
                                7'h4E, 7'h3D, 7'h4F, 7'h47};

    seg_scan_ctrl #(.SCAN_DIV(c_DIV), .BLANK(c_BLANK)) dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .mask_in     (mask_in),
        .load        (load),
        .pending     (pending),
        .frame_start (frame_start),
        .num_csn     (num_csn),
        .num_a_g     (num_a_g)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h (pos %0d)", tag, got, exp, m_pos);
        end
    endtask

    // Predict the outputs of the coming edge, advance the model, clock, check.
    task automatic tick();
        logic [7:0] e_csn;
        logic [6:0] e_seg;
        logic       e_fs;
        int         digit, sub;
        if (reset) begin
            e_csn = 8'hFF; e_seg = 7'h00; e_fs = 1'b0;
            m_pos = 0; m_disp = 0; m_sdata = 0; m_mask = 0; m_smask = 0; m_pend = 0;
        end else begin
            digit = m_pos / c_DIV;
            sub   = m_pos % c_DIV;
            if (sub >= c_BLANK && m_mask[digit]) begin
                e_csn = 8'hFF;
                e_csn[digit] = 1'b0;
                e_seg = segtab[(m_disp >> (4 * digit)) & 32'hF];
            end else begin
                e_csn = 8'hFF; e_seg = 7'h00;
            end
            e_fs = (m_pos == c_FRAME - 1);
            if (m_pos == c_FRAME - 1) begin
                if (load) begin
                    m_disp = data_in; m_mask = mask_in;
                end else if (m_pend) begin
                    m_disp = m_sdata; m_mask = m_smask;
                end
                m_pend = 0;
            end else if (load) begin
                m_sdata = data_in; m_smask = mask_in; m_pend = 1;
            end
            m_pos = (m_pos + 1) % c_FRAME;
        end
        @(posedge clk);
        #1;
        check("num_csn", 32'(num_csn), 32'(e_csn));
        check("num_a_g", 32'(num_a_g), 32'(e_seg));
        check("frame_start", 32'(frame_start), 32'(e_fs));
        check("pending", 32'(pending), 32'(m_pend));
        check("one_digit", 32'($countones(~num_csn) <= 1), 32'd1);
    endtask

    task automatic run_to(input int p);
        for (int i = 0; i < c_FRAME && m_pos != p; i++) tick();
    endtask

    task automatic pulse_load(input logic [31:0] d, input logic [7:0] m);
        data_in = d; mask_in = m; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    initial begin
        int fs_count, lit0, lit7;
        reset = 1'b1; data_in = 32'h0; mask_in = 8'h0; load = 1'b0;
        m_pos = 0; m_disp = 0; m_sdata = 0; m_mask = 0; m_smask = 0; m_pend = 0;
        repeat (3) tick();
        check("reset_csn", 32'(num_csn), 32'hFF);
        check("reset_seg", 32'(num_a_g), 32'h00);
        reset = 1'b0;

        // 1: three dark frames, one frame_start per frame
        fs_count = 0;
        for (int i = 0; i < 3 * c_FRAME; i++) begin
            tick();
            if (frame_start) fs_count++;
        end
        check("s1_frame_count", 32'(fs_count), 32'd3);

        // 2: all digits 0..7 shown
        run_to(20);
        pulse_load(32'h76543210, 8'hFF);
        check("s2_pending", 32'(pending), 32'd1);
        run_to(c_FRAME - 1);
        tick();
        check("s2_pend_clear", 32'(pending), 32'd0);
        lit0 = 0; lit7 = 0;
        for (int i = 0; i < c_FRAME; i++) begin
            tick();
            if (num_csn == 8'hFE && num_a_g == 7'h7E) lit0++;
            if (num_csn == 8'h7F && num_a_g == 7'h70) lit7++;
        end
        check("s2_digit0_lit", 32'(lit0), 32'd6);
        check("s2_digit7_lit", 32'(lit7), 32'd6);

        // 3: last load before the boundary wins
        run_to(10);
        pulse_load(32'h12345678, 8'hFF);
        run_to(30);
        pulse_load(32'h9ABCDEF0, 8'hFF);
        run_to(c_FRAME - 1);
        tick();
        lit7 = 0;
        for (int i = 0; i < c_FRAME; i++) begin
            tick();
            if (num_csn == 8'h7F && num_a_g == 7'h7B) lit7++;
        end
        check("s3_digit7_9", 32'(lit7), 32'd6);

        // 4: load exactly in the boundary cycle
        run_to(c_FRAME - 1);
        pulse_load(32'hFFFFFFFF, 8'hFF);
        check("s4_pending", 32'(pending), 32'd0);
        repeat (c_FRAME) tick();

        // 5: only digits 0 and 2 enabled
        run_to(5);
        pulse_load(32'h00000000, 8'h05);
        repeat (2 * c_FRAME) tick();

        // 6: reset during digit 4 DRIVE with a load pending
        run_to(2);
        pulse_load(32'hA5A5A5A5, 8'hFF);
        run_to(4 * c_DIV + 4);
        reset = 1'b1;
        tick();
        check("s6_pending", 32'(pending), 32'd0);
        check("s6_csn", 32'(num_csn), 32'hFF);
        reset = 1'b0;
        repeat (c_FRAME + 4) tick();

        // Random loads, including ones that land on the boundary
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                data_in = $urandom;
                mask_in = 8'($urandom);
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            tick();
        end
        load = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
